// File: rtl/ct_spsram_512x44_ctrl_pkg.sv
// Shared types and default geometry for the 512x44 SRAM sequencer.
package ct_spsram_ctrl_pkg;
   localparam int ADDR_WIDTH = 9;
   localparam int DATA_WIDTH = 44;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;
endpackage

// File: rtl/ct_spsram_512x44_ctrl_if.sv
// Requester-side and SRAM-side signal bundle for the SRAM sequencer.
// slave = the controller, master = requesters plus the SRAM macro.
interface ct_spsram_512x44_ctrl_if #(
   parameter int ADDR_WIDTH = ct_spsram_ctrl_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ct_spsram_ctrl_pkg::DATA_WIDTH
);
   logic                  flush_req;
   logic                  init_busy;
   logic                  rq0_req,   rq1_req;
   logic                  rq0_wr,    rq1_wr;
   logic [ADDR_WIDTH-1:0] rq0_addr,  rq1_addr;
   logic [DATA_WIDTH-1:0] rq0_wdata, rq1_wdata;
   logic [DATA_WIDTH-1:0] rq0_wmask, rq1_wmask;
   logic                  rq0_gnt,   rq1_gnt;
   logic                  rq0_rvld,  rq1_rvld;
   logic [DATA_WIDTH-1:0] rdata;
   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [DATA_WIDTH-1:0] sram_q;

   modport slave (
      input  flush_req, rq0_req, rq1_req, rq0_wr, rq1_wr, rq0_addr, rq1_addr,
             rq0_wdata, rq1_wdata, rq0_wmask, rq1_wmask, sram_q,
      output init_busy, rq0_gnt, rq1_gnt, rq0_rvld, rq1_rvld, rdata,
             sram_a, sram_cen, sram_gwen, sram_d, sram_wen
   );

   modport master (
      output flush_req, rq0_req, rq1_req, rq0_wr, rq1_wr, rq0_addr, rq1_addr,
             rq0_wdata, rq1_wdata, rq0_wmask, rq1_wmask, sram_q,
      input  init_busy, rq0_gnt, rq1_gnt, rq0_rvld, rq1_rvld, rdata,
             sram_a, sram_cen, sram_gwen, sram_d, sram_wen
   );
endinterface

// File: rtl/ct_spsram_512x44_ctrl_arb.sv
// Two-way round-robin arbiter. Grant is combinational; the pointer only
// moves when both requesters compete, so a lone requester never disturbs
// the fairness order.
module ct_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   logic r_ptr;

   // grant selection: single requester wins outright, contention uses pointer
   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (&i_req) o_gnt = r_ptr ? 2'b10 : 2'b01;
         else        o_gnt = i_req;
      end
   end

   // pointer flips to the loser after every contended grant
   always_ff @(posedge i_clk) begin
      if (i_rst)                  r_ptr <= 1'b0;
      else if (i_en && (&i_req))  r_ptr <= ~r_ptr;
   end
endmodule

// File: rtl/ct_spsram_512x44_ctrl.sv
// Sequencer + arbiter in front of a 512x44 single-port SRAM. Clears the
// array after reset or flush, then serves two requesters round-robin and
// returns read data one cycle after the read grant.
module ct_spsram_512x44_ctrl #(
   parameter int ADDR_WIDTH = ct_spsram_ctrl_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ct_spsram_ctrl_pkg::DATA_WIDTH
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst,
   ct_spsram_512x44_ctrl_if.slave  bus
);
   import ct_spsram_ctrl_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] L_LAST = '1;

   state_e                r_state;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [1:0]            r_rvld;
   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   logic                  w_run;
   logic                  w_wr;

   assign w_run = (r_state == RUN);
   assign w_req = {bus.rq1_req, bus.rq0_req};

   ct_rr_arb2 u_arb (
      .i_clk (forever_cpuclk),
      .i_rst (cpurst),
      .i_en  (w_run),
      .i_req (w_req),
      .o_gnt (w_gnt)
   );

   assign bus.rq0_gnt   = w_gnt[0];
   assign bus.rq1_gnt   = w_gnt[1];
   assign bus.rq0_rvld  = r_rvld[0];
   assign bus.rq1_rvld  = r_rvld[1];
   assign bus.rdata     = bus.sram_q;
   assign bus.init_busy = ~w_run;
   assign w_wr          = w_gnt[1] ? bus.rq1_wr : bus.rq0_wr;

   // SRAM pin drive: clear writes in INIT, granted access in RUN, idle otherwise
   always_comb begin
      bus.sram_cen  = 1'b1;
      bus.sram_gwen = 1'b1;
      bus.sram_wen  = '1;
      bus.sram_a    = '0;
      bus.sram_d    = '0;
      if (!w_run) begin
         bus.sram_cen  = 1'b0;
         bus.sram_gwen = 1'b0;
         bus.sram_wen  = '0;
         bus.sram_a    = r_clr_cnt;
      end else if (|w_gnt) begin
         bus.sram_cen = 1'b0;
         bus.sram_a   = w_gnt[1] ? bus.rq1_addr : bus.rq0_addr;
         if (w_wr) begin
            bus.sram_gwen = 1'b0;
            bus.sram_wen  = w_gnt[1] ? ~bus.rq1_wmask : ~bus.rq0_wmask;
            bus.sram_d    = w_gnt[1] ?  bus.rq1_wdata :  bus.rq0_wdata;
         end
      end
   end

   // state, clear counter and read-valid pipe; clear exits at the all-ones
   // address so the counter never wraps while in INIT
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_state   <= INIT;
         r_clr_cnt <= '0;
         r_rvld    <= 2'b00;
      end else begin
         r_rvld <= {w_gnt[1] & ~bus.rq1_wr, w_gnt[0] & ~bus.rq0_wr};
         case (r_state)
            INIT: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == L_LAST) r_state <= RUN;
            end
            RUN: begin
               if (bus.flush_req) begin
                  r_state   <= INIT;
                  r_clr_cnt <= '0;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_ct_spsram_512x44_ctrl.sv
// Directed bench for ct_spsram_512x44_ctrl with a behavioural SRAM macro.
module tb_ct_spsram_512x44_ctrl;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   ct_spsram_512x44_ctrl_if bus ();

   ct_spsram_512x44_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .bus            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM macro model: active-low CEN/GWEN/WEN, registered read
   logic [43:0] mem [512];
   logic [43:0] q;
   assign bus.sram_q = q;
   initial begin
      q = '0;
      for (int i = 0; i < 512; i++) mem[i] = 44'hDEA_DBEE_F000 | 44'(i);
   end
   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_gwen)
            mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
         else
            q <= mem[bus.sram_a];
      end
   end

   task automatic idle();
      bus.flush_req = 0;
      bus.rq0_req = 0; bus.rq0_wr = 0; bus.rq0_addr = '0; bus.rq0_wdata = '0; bus.rq0_wmask = '0;
      bus.rq1_req = 0; bus.rq1_wr = 0; bus.rq1_addr = '0; bus.rq1_wdata = '0; bus.rq1_wmask = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({bus.init_busy, bus.sram_cen, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_rvld, bus.rq1_rvld} !== 6'b100000)
         $display("FAIL reset_state got=%b exp=100000",
                  {bus.init_busy, bus.sram_cen, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_rvld, bus.rq1_rvld});
      else n_pass++;
      @(negedge clk); rst = 1'b0; #1;
      for (int i = 0; i < 512; i++) begin
         n_chk++;
         if ({bus.init_busy, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_d, bus.sram_wen} !==
             {1'b1, 1'b0, 1'b0, 9'(i), 44'h0, 44'h0})
            $display("FAIL init_step i=%0d busy=%b cen=%b gwen=%b a=%0d d=%h", i,
                     bus.init_busy, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_d);
         else n_pass++;
         @(negedge clk); #1;
      end
      n_chk++;
      if (bus.init_busy !== 1'b0) $display("FAIL init_done busy=%b exp=0", bus.init_busy);
      else n_pass++;
      // read of the last entry after the clear
      bus.rq0_req = 1; bus.rq0_wr = 0; bus.rq0_addr = 9'h1FF; #1;
      n_chk++;
      if ({bus.rq0_gnt, bus.sram_cen, bus.sram_gwen, bus.sram_a} !== {1'b1, 1'b0, 1'b1, 9'h1FF})
         $display("FAIL rd1ff_issue gnt=%b cen=%b gwen=%b a=%h", bus.rq0_gnt, bus.sram_cen, bus.sram_gwen, bus.sram_a);
      else n_pass++;
      @(negedge clk); idle(); #1;
      n_chk++;
      if ({bus.rq0_rvld, bus.rq1_rvld, bus.rdata} !== {1'b1, 1'b0, 44'h0})
         $display("FAIL rd1ff_data rvld0=%b rvld1=%b rdata=%h exp 1 0 0", bus.rq0_rvld, bus.rq1_rvld, bus.rdata);
      else n_pass++;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      bus.rq0_req = 1; bus.rq0_wr = 1; bus.rq0_addr = 9'd5; bus.rq0_wdata = 44'hABC; bus.rq0_wmask = '1; #1;
      n_chk++;
      if ({bus.rq0_gnt, bus.sram_gwen, bus.sram_wen, bus.sram_d} !== {1'b1, 1'b0, 44'h0, 44'hABC})
         $display("FAIL wr5_issue gnt=%b gwen=%b wen=%h d=%h", bus.rq0_gnt, bus.sram_gwen, bus.sram_wen, bus.sram_d);
      else n_pass++;
      @(negedge clk); idle();
      bus.rq1_req = 1; bus.rq1_wr = 0; bus.rq1_addr = 9'd5; #1;
      n_chk++;
      if ({bus.rq1_gnt, bus.rq0_gnt, bus.rq0_rvld, bus.sram_a} !== {1'b1, 1'b0, 1'b0, 9'd5})
         $display("FAIL rd5_issue gnt1=%b gnt0=%b rvld0=%b a=%0d exp 1 0 0 5", bus.rq1_gnt, bus.rq0_gnt, bus.rq0_rvld, bus.sram_a);
      else n_pass++;
      @(negedge clk); idle(); #1;
      n_chk++;
      if ({bus.rq1_rvld, bus.rdata} !== {1'b1, 44'hABC})
         $display("FAIL rd5_data rvld1=%b rdata=%h exp 1 abc", bus.rq1_rvld, bus.rdata);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [43:0] exp_d;
      @(negedge clk);
      bus.rq0_req = 1; bus.rq0_wr = 0; bus.rq0_addr = 9'd5;
      bus.rq1_req = 1; bus.rq1_wr = 0; bus.rq1_addr = 9'h10;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_chk++;
         if ({bus.rq0_gnt, bus.rq1_gnt} !== {(k % 2) == 0, (k % 2) == 1})
            $display("FAIL rr_gnt k=%0d gnt0=%b gnt1=%b", k, bus.rq0_gnt, bus.rq1_gnt);
         else n_pass++;
         if (k > 0) begin
            exp_d = ((k - 1) % 2 == 0) ? 44'hABC : 44'h0;
            n_chk++;
            if ({bus.rq0_rvld, bus.rq1_rvld, bus.rdata} !== {(k - 1) % 2 == 0, (k - 1) % 2 == 1, exp_d})
               $display("FAIL rr_rvld k=%0d rvld0=%b rvld1=%b rdata=%h exp=%h", k, bus.rq0_rvld, bus.rq1_rvld, bus.rdata, exp_d);
            else n_pass++;
         end
         @(negedge clk);
      end
      idle(); #1;
      n_chk++;
      if ({bus.rq0_rvld, bus.rq1_rvld, bus.rdata} !== {1'b0, 1'b1, 44'h0})
         $display("FAIL rr_last rvld0=%b rvld1=%b rdata=%h exp 0 1 0", bus.rq0_rvld, bus.rq1_rvld, bus.rdata);
      else n_pass++;
   endtask

   task automatic test_partial_write();
      @(negedge clk);
      bus.rq0_req = 1; bus.rq0_wr = 1; bus.rq0_addr = 9'd7; bus.rq0_wdata = 44'hFFF; bus.rq0_wmask = '1;
      @(negedge clk);
      bus.rq0_wdata = 44'h000; bus.rq0_wmask = 44'h00F; #1;
      n_chk++;
      if ({bus.rq0_gnt, bus.sram_gwen, bus.sram_wen} !== {1'b1, 1'b0, ~44'h00F})
         $display("FAIL pw_wen gnt=%b gwen=%b wen=%h exp=%h", bus.rq0_gnt, bus.sram_gwen, bus.sram_wen, ~44'h00F);
      else n_pass++;
      // zero-mask write is still issued and granted but changes nothing
      @(negedge clk);
      bus.rq0_wdata = 44'h0; bus.rq0_wmask = 44'h0; #1;
      n_chk++;
      if ({bus.rq0_gnt, bus.sram_cen, bus.sram_gwen, bus.sram_wen} !== {1'b1, 1'b0, 1'b0, 44'hFFF_FFFF_FFFF})
         $display("FAIL zm_issue gnt=%b cen=%b gwen=%b wen=%h", bus.rq0_gnt, bus.sram_cen, bus.sram_gwen, bus.sram_wen);
      else n_pass++;
      @(negedge clk);
      bus.rq0_wr = 0; #1;
      @(negedge clk); idle(); #1;
      n_chk++;
      if ({bus.rq0_rvld, bus.rdata} !== {1'b1, 44'hFF0})
         $display("FAIL pw_read rvld0=%b rdata=%h exp 1 ff0", bus.rq0_rvld, bus.rdata);
      else n_pass++;
   endtask

   task automatic test_flush();
      @(negedge clk);
      bus.rq0_req = 1; bus.rq0_wr = 0; bus.rq0_addr = 9'd5; bus.flush_req = 1; #1;
      n_chk++;
      if (bus.rq0_gnt !== 1'b1) $display("FAIL flush_cycle_gnt gnt0=%b exp=1", bus.rq0_gnt);
      else n_pass++;
      @(negedge clk);
      bus.flush_req = 0;
      bus.rq1_req = 1; bus.rq1_wr = 0; bus.rq1_addr = 9'd7; #1;
      n_chk++;
      if ({bus.rq0_rvld, bus.rdata} !== {1'b1, 44'hABC})
         $display("FAIL flush_cycle_read rvld0=%b rdata=%h exp 1 abc", bus.rq0_rvld, bus.rdata);
      else n_pass++;
      for (int i = 0; i < 512; i++) begin
         n_chk++;
         if ({bus.init_busy, bus.rq0_gnt, bus.rq1_gnt, bus.sram_a} !== {1'b1, 1'b0, 1'b0, 9'(i)})
            $display("FAIL flush_init i=%0d busy=%b gnt0=%b gnt1=%b a=%0d", i, bus.init_busy, bus.rq0_gnt, bus.rq1_gnt, bus.sram_a);
         else n_pass++;
         @(negedge clk); #1;
      end
      n_chk++;
      if ({bus.init_busy, bus.rq0_gnt, bus.rq1_gnt} !== 3'b010)
         $display("FAIL flush_run busy=%b gnt0=%b gnt1=%b exp 0 1 0", bus.init_busy, bus.rq0_gnt, bus.rq1_gnt);
      else n_pass++;
      @(negedge clk);
      bus.rq0_req = 0; #1;
      n_chk++;
      if ({bus.rq0_rvld, bus.rdata, bus.rq1_gnt} !== {1'b1, 44'h0, 1'b1})
         $display("FAIL flush_rd5 rvld0=%b rdata=%h gnt1=%b exp 1 0 1", bus.rq0_rvld, bus.rdata, bus.rq1_gnt);
      else n_pass++;
      @(negedge clk); idle(); #1;
      n_chk++;
      if ({bus.rq1_rvld, bus.rdata} !== {1'b1, 44'h0})
         $display("FAIL flush_rd7 rvld1=%b rdata=%h exp 1 0", bus.rq1_rvld, bus.rdata);
      else n_pass++;
   endtask

   task automatic test_reset_mid_clear();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
      end
      n_chk++;
      if (bus.sram_a !== 9'd200) $display("FAIL mid_reach a=%0d exp=200", bus.sram_a);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk); #1;
      n_chk++;
      if ({bus.init_busy, bus.sram_a} !== {1'b1, 9'd0})
         $display("FAIL mid_restart busy=%b a=%0d exp 1 0", bus.init_busy, bus.sram_a);
      else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 512; i++) begin
         n_chk++;
         if ({bus.init_busy, bus.sram_a, bus.sram_gwen} !== {1'b1, 9'(i), 1'b0})
            $display("FAIL mid_init i=%0d busy=%b a=%0d gwen=%b", i, bus.init_busy, bus.sram_a, bus.sram_gwen);
         else n_pass++;
         @(negedge clk); #1;
      end
      n_chk++;
      if (bus.init_busy !== 1'b0) $display("FAIL mid_done busy=%b exp=0", bus.init_busy);
      else n_pass++;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_partial_write();
      test_flush();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
